// File: rtl/ascon_hash_padder.sv
// Ascon hash front end: packs message bytes into 64-bit rate blocks,
// appends 0x80 + zero padding and flags the final block.
module ascon_hash_padder #(
  parameter int RATE_BYTES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        in_empty,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic [63:0] blk_data,
  output logic        blk_last
);

  localparam logic [2:0] LastIdx = 3'(RATE_BYTES - 1);
  localparam logic [63:0] PadBlk = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {FILL, EMIT, PADBLK} state_t;

  state_t      state, state_nx;
  logic [2:0]  idx, idx_nx;
  logic [63:0] acc, acc_nx;
  logic [63:0] data_q, data_nx;
  logic        last_q, last_nx;
  logic        pad_q, pad_nx;

  logic [5:0]  sh_byte, sh_pad;
  logic [63:0] byte_w, pad_here, pad_next;

  // slot idx lives at bits [63-8*idx -: 8]
  assign sh_byte  = {~idx, 3'b000};
  assign sh_pad   = sh_byte - 6'd8;
  assign byte_w   = {56'd0, in_data} << sh_byte;
  assign pad_here = 64'h80 << sh_byte;
  assign pad_next = 64'h80 << sh_pad;

  assign in_ready  = (state == FILL);
  assign blk_valid = (state != FILL);
  assign blk_data  = data_q;
  assign blk_last  = last_q;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    acc_nx   = acc;
    data_nx  = data_q;
    last_nx  = last_q;
    pad_nx   = pad_q;
    unique case (state)
      FILL: begin
        if (in_valid) begin
          if (in_empty) begin
            if (in_last) begin
              data_nx  = acc | pad_here;
              last_nx  = 1'b1;
              idx_nx   = '0;
              acc_nx   = '0;
              state_nx = EMIT;
            end
          end else if (idx == LastIdx) begin
            data_nx  = acc | byte_w;
            last_nx  = 1'b0;
            pad_nx   = in_last;
            idx_nx   = '0;
            acc_nx   = '0;
            state_nx = EMIT;
          end else if (in_last) begin
            data_nx  = acc | byte_w | pad_next;
            last_nx  = 1'b1;
            idx_nx   = '0;
            acc_nx   = '0;
            state_nx = EMIT;
          end else begin
            acc_nx = acc | byte_w;
            idx_nx = idx + 3'd1;
          end
        end
      end
      EMIT: begin
        if (blk_ready) begin
          if (pad_q) begin
            data_nx  = PadBlk;
            last_nx  = 1'b1;
            pad_nx   = 1'b0;
            state_nx = PADBLK;
          end else begin
            state_nx = FILL;
          end
        end
      end
      PADBLK: begin
        if (blk_ready) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FILL;
      idx    <= '0;
      acc    <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      pad_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      acc    <= acc_nx;
      data_q <= data_nx;
      last_q <= last_nx;
      pad_q  <= pad_nx;
    end
  end

endmodule

// File: tb/tb_ascon_hash_padder.sv
// Bench for ascon_hash_padder: directed cases plus random messages,
// checked by a scoreboard fed from a padding reference model.
module tb_ascon_hash_padder;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last, in_empty;
  logic [7:0]  in_data;
  logic        blk_valid, blk_ready, blk_last;
  logic [63:0] blk_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int vcnt = 0;
  bit rnd_ready = 1'b0;

  logic [64:0] exp_q[$];

  logic        prev_v = 1'b0;
  logic        prev_hs = 1'b0;
  logic [63:0] prev_d = '0;
  logic        prev_l = 1'b0;

  ascon_hash_padder #(.RATE_BYTES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_empty(in_empty),
    .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_last(blk_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rnd_ready) begin
      #2;
      blk_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Reference: message ++ 0x80 ++ zeros up to a multiple of 8 bytes
  task automatic push_model(input bq_t m);
    bq_t p;
    int n;
    logic [63:0] d;
    logic l;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 8 != 0) p.push_back(8'h00);
    n = p.size() / 8;
    for (int k = 0; k < n; k++) begin
      d = '0;
      for (int j = 0; j < 8; j++) d = {d[55:0], p[8*k+j]};
      l = (k == n - 1);
      exp_q.push_back({l, d});
    end
  endtask

  always @(negedge clk) begin
    logic [64:0] e;
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (blk_valid) vcnt++;
      checks++;
      if (in_ready === blk_valid) begin
        errors++;
        $display("FAIL overlap: in_ready=%b blk_valid=%b", in_ready, blk_valid);
      end
      if (blk_valid && prev_v && !prev_hs) begin
        checks++;
        if (blk_data !== prev_d || blk_last !== prev_l) begin
          errors++;
          $display("FAIL hold: got %h/%b want %h/%b",
                   blk_data, blk_last, prev_d, prev_l);
        end
      end
      if (blk_valid && blk_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected block: got %h/%b want none",
                   blk_data, blk_last);
        end else begin
          e = exp_q.pop_front();
          if ({blk_last, blk_data} !== e) begin
            errors++;
            $display("FAIL block: got %h last=%b want %h last=%b",
                     blk_data, blk_last, e[63:0], e[64]);
          end
        end
      end
      prev_v  = blk_valid;
      prev_hs = blk_valid && blk_ready;
      prev_d  = blk_data;
      prev_l  = blk_last;
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l,
                           input logic e);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_empty = e;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept timeout: in_ready=%b want 1", in_ready);
    end
    acc_cyc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic send_msg(input bq_t m, input bit viol,
                          output int first_cyc);
    push_model(m);
    first_cyc = 0;
    if (m.size() == 0) begin
      send_beat(8'($urandom), 1'b1, 1'b1);
      first_cyc = acc_cyc;
    end else begin
      for (int i = 0; i < m.size(); i++) begin
        if (viol && i == 1) send_beat(8'($urandom), 1'b0, 1'b1);
        send_beat(m[i], (i == m.size() - 1), 1'b0);
        if (i == 0) first_cyc = acc_cyc;
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_empty = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    idle();
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d blocks outstanding want 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    bq_t m;
    int c1, c2, t;
    bit bp_ok;

    rst_n = 1'b0;
    blk_ready = 1'b1;
    idle();
    in_data = '0;
    #3;
    chk("rst blk_valid", 64'(blk_valid), 64'd0);
    chk("rst blk_data", blk_data, 64'd0);
    #9 rst_n = 1'b1;
    @(negedge clk);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst blk_last", 64'(blk_last), 64'd0);
    chk("rst blk_data2", blk_data, 64'd0);

    // 3-byte message, valid for exactly one cycle
    vcnt = 0;
    m = '{8'h41, 8'h42, 8'h43};
    send_msg(m, 1'b0, c1);
    drain();
    chk("3B valid cycles", 64'(vcnt), 64'd1);

    // 8-byte message: full block then a padding-only block
    m = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    send_msg(m, 1'b0, c1);
    drain();

    // empty message
    m = {};
    send_msg(m, 1'b0, c1);
    drain();

    // backpressure on an 11-byte message
    blk_ready = 1'b0;
    m = {};
    for (int i = 0; i < 11; i++) m.push_back(8'(8'h10 + i));
    fork
      send_msg(m, 1'b0, c1);
      begin
        t = 0;
        while (!blk_valid && t < 300) begin
          @(negedge clk);
          t++;
        end
        bp_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
          if (blk_valid !== 1'b1 || in_ready !== 1'b0 ||
              blk_data !== 64'h1011121314151617) bp_ok = 1'b0;
          @(negedge clk);
        end
        chk("backpressure hold", 64'(bp_ok), 64'd1);
        @(posedge clk);
        #2 blk_ready = 1'b1;
      end
    join
    drain();

    // reset in the middle of a block
    m = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    for (int i = 0; i < 5; i++) send_beat(m[i], 1'b0, 1'b0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst blk_valid", 64'(blk_valid), 64'd0);
    chk("midrst blk_data", blk_data, 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    m = '{8'hFF};
    send_msg(m, 1'b0, c1);
    drain();

    // back-to-back 7-byte messages
    m = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    send_msg(m, 1'b0, c1);
    m = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6};
    send_msg(m, 1'b0, c2);
    drain();
    chk("b2b gap", 64'(c2 - c1), 64'd8);

    // random messages with random backpressure and protocol noise
    rnd_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      m = {};
      t = $urandom_range(0, 20);
      for (int i = 0; i < t; i++) m.push_back(8'($urandom));
      send_msg(m, ($urandom_range(0, 4) == 0), c1);
      if ($urandom_range(0, 2) == 0) begin
        idle();
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
    end
    idle();
    rnd_ready = 1'b0;
    @(posedge clk);
    #2 blk_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascon_hash_padder.md
# ascon_hash_padder

Byte-stream front end for the Ascon hash core. It packs an incoming message byte stream into 64-bit rate blocks and applies Ascon padding (a single 0x80 byte, then zero fill). It hands each block to the permutation/absorb stage over a valid/ready handshake and marks the final padded block with `blk_last`. It sits directly upstream of the permutation core and is the only path by which message data enters the hash datapath.

## Interface
- `RATE_BYTES`, default 8: rate block size in bytes. Only 8 is supported; the block is 64 bits.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  padder can accept a beat.
- `in_data`  in  8  message byte.
- `in_last`  in  1  beat is the final beat of the message.
- `in_empty`  in  1  beat carries no byte; legal only with `in_last`; `in_data` is ignored.
- `blk_valid`  out  1  `blk_data` holds a complete block.
- `blk_ready`  in  1  downstream accepts the block.
- `blk_data`  out  64  rate block, big-endian: first message byte in [63:56].
- `blk_last`  out  1  block is the final, padded block of the message.

## Operation
- **Registers:**
  - `idx[2:0]`: next byte slot.
  - `acc[63:0]`: accumulator.
  - `blk_data`, `blk_last`, `blk_valid`.
  - State: FILL, EMIT, PADBLK.
- **FILL:** `in_ready`=1, `blk_valid`=0. On each accepted beat (`in_valid` & `in_ready`):
  - **Non-last byte, `idx`<7:** write the byte at bits [63-8*idx -: 8]; `idx`++.
  - **Non-last byte, `idx`=7:** `blk_data` <= `acc` with byte 7 inserted; `blk_last`<=0; `idx`<=0; `acc`<=0; go to EMIT.
  - **Last byte, `idx`<7:** insert the byte, put 0x80 at slot `idx`+1, zeros below; `blk_last`<=1; go to EMIT.
  - **Last byte, `idx`=7:** emit the full block with `blk_last`=0, go to EMIT, and set an internal `pad_pending`.
  - **`in_empty` & `in_last`:** put 0x80 at slot `idx`, zeros below; `blk_last`<=1; go to EMIT.
    - An empty message (first beat has `in_empty`) yields 0x8000000000000000 with `blk_last`=1.
- **EMIT:** `blk_valid`=1, `in_ready`=0. `blk_data` and `blk_last` hold stable until `blk_valid` & `blk_ready`. On handshake:
  - `pad_pending` → PADBLK, with `blk_data`<=0x8000000000000000, `blk_last`<=1, `pad_pending`<=0.
  - otherwise → FILL; after a `blk_last` block, `idx` and `acc` are cleared.
- **PADBLK:** `blk_valid`=1, `in_ready`=0. On handshake → FILL.
- **`in_empty` without `in_last`:** protocol violation; the beat is accepted and ignored.
- `in_data` is sampled only on accepted beats; `in_ready` is a function of state only and does not depend on `in_valid`.

## Timing
- **Reset values:**
  - Outputs: `blk_valid`=0, `blk_last`=0, `blk_data`=0; `in_ready`=1 in the first cycle after release.
  - Internal: state=FILL, `idx`=0, `acc`=0, `pad_pending`=0.
- **Latency:** `blk_valid` rises in the cycle after the beat that completes or terminates a block.
- **Throughput:** 8 byte cycles plus 1 emit cycle per block when `blk_ready` is held high, i.e. 9 cycles per 64-bit block.
- **Backpressure:** with `blk_ready`=0, `blk_valid` stays 1 and `blk_data`/`blk_last` stay constant indefinitely; `in_ready` stays 0.
- **No overlap:** input acceptance and output handshake never occur in the same cycle.
- **Reset mid-operation:** asserting `rst_n`=0 at any time discards the partial block and any pending block; outputs return to reset values immediately (asynchronous).
- **Message boundaries:** a new message may start in the FILL cycle immediately after the last block's handshake.

## Test plan
- **3-byte message:** bytes 0x41,0x42,0x43 (`in_last` on 0x43), `blk_ready`=1 → one block 0x4142438000000000, `blk_last`=1, `blk_valid` high exactly 1 cycle.
- **8-byte message:** bytes 0x00..0x07 → block 0x0001020304050607 with `blk_last`=0, then 0x8000000000000000 with `blk_last`=1, on consecutive handshakes.
- **Empty message:** single beat with `in_empty`=1, `in_last`=1 → one block 0x8000000000000000, `blk_last`=1.
- **Backpressure:** 11-byte message 0x10..0x1A with `blk_ready` held 0 for 20 cycles after the first `blk_valid`:
  - `blk_data` stays 0x1011121314151617 and `in_ready` stays 0 throughout;
  - after release: 0x18191A8000000000 with `blk_last`=1.
- **Reset mid-block:** 5 bytes accepted, `rst_n` pulsed low → no block emitted; a following 1-byte message 0xFF yields 0xFF80000000000000.
- **Back-to-back messages:** two 7-byte messages streamed continuously → 0x..80 padded blocks each with `blk_last`=1; second message accepted the cycle after the first handshake.
